// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load/store size codes, LSU FSM states and
// lane helpers used by the memory stage.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2,
    DONE        = 2'd3
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return offset[0];
      default: return |offset;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'b00:   return 4'b0001 << offset;
      2'b01:   return 4'b0011 << {offset[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/response bus between the load/store unit and memory.
interface load_store_unit_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     dmem_req;
  logic                     dmem_we;
  logic [ADDRESS_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0]    dmem_wdata;
  logic [3:0]               dmem_be;
  logic                     dmem_gnt;
  logic                     dmem_rvalid;
  logic [DATA_WIDTH-1:0]    dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/load_align.sv
// Moves the addressed byte/halfword of a read word to bit 0 and extends it.
module load_align
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            offset_i,
  input  logic [2:0]            funct3_i,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    case (funct3_i)
      F3_B:    data_o = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      F3_BU:   data_o = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      F3_HU:   data_o = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Memory pipeline stage: M-stage register, data-memory handshake and load
// alignment, stalling upstream while an access is outstanding.
//   state       | meaning
//   IDLE        | no access outstanding; aligned mem op in M requests now
//   WAIT_GNT    | request presented, holding bus until gnt
//   WAIT_RVALID | load granted, waiting for read data
//   DONE        | load data captured; releases the stage for one cycle
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reg_write_e,
  input  logic                     mem_read_e,
  input  logic                     mem_write_e,
  input  logic [1:0]               result_src_e,
  input  logic [2:0]               funct3_e,
  input  logic [ADDRESS_WIDTH-1:0] alu_result_e,
  input  logic [DATA_WIDTH-1:0]    write_data_e,
  input  logic [4:0]               rd_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
  output logic                     reg_write_m,
  output logic [1:0]               result_src_m,
  output logic [ADDRESS_WIDTH-1:0] alu_result_m,
  output logic [4:0]               rd_m,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
  output logic [DATA_WIDTH-1:0]    read_data_m,
  output logic                     stall_m,
  output logic                     misaligned_m,
  load_store_unit_if.master        dmem
);
  logic                     reg_write_q, mem_read_q, mem_write_q;
  logic [1:0]               result_src_q;
  logic [2:0]               funct3_q;
  logic [ADDRESS_WIDTH-1:0] alu_result_q, pc_plus4_q;
  logic [DATA_WIDTH-1:0]    write_data_q, load_q, load_data;
  logic [4:0]               rd_q;
  lsu_state_e               state_q;
  logic                     mem_op, misaligned, issue, stall;
  logic [DATA_WIDTH-1:0]    wdata;

  assign mem_op     = mem_read_q | mem_write_q;
  assign misaligned = mem_op & is_misaligned(funct3_q, alu_result_q[1:0]);
  assign issue      = mem_op & ~misaligned & ((state_q == IDLE) | (state_q == WAIT_GNT));
  // A store is finished the cycle it is granted, so the stage is released then
  // even from WAIT_GNT; otherwise the same store would be re-issued.
  assign stall      = (state_q == WAIT_RVALID) | (issue & ~(mem_write_q & dmem.dmem_gnt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      funct3_q     <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      rd_q         <= '0;
      pc_plus4_q   <= '0;
    end else if (!stall) begin
      reg_write_q  <= reg_write_e;
      mem_read_q   <= mem_read_e;
      mem_write_q  <= mem_write_e;
      result_src_q <= result_src_e;
      funct3_q     <= funct3_e;
      alu_result_q <= alu_result_e;
      write_data_q <= write_data_e;
      rd_q         <= rd_e;
      pc_plus4_q   <= pc_plus4_e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      load_q  <= '0;
    end else begin
      case (state_q)
        IDLE, WAIT_GNT: begin
          if (issue) begin
            if (dmem.dmem_gnt) state_q <= mem_write_q ? IDLE : WAIT_RVALID;
            else               state_q <= WAIT_GNT;
          end
        end
        WAIT_RVALID: begin
          if (dmem.dmem_rvalid) begin
            load_q  <= load_data;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .rdata_i  (dmem.dmem_rdata),
    .offset_i (alu_result_q[1:0]),
    .funct3_i (funct3_q),
    .data_o   (load_data)
  );

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   wdata = {(DATA_WIDTH/8){write_data_q[7:0]}};
      2'b01:   wdata = {(DATA_WIDTH/16){write_data_q[15:0]}};
      default: wdata = write_data_q;
    endcase
  end

  assign dmem.dmem_req   = issue;
  assign dmem.dmem_we    = mem_write_q;
  assign dmem.dmem_addr  = {alu_result_q[ADDRESS_WIDTH-1:2], 2'b00};
  assign dmem.dmem_wdata = wdata;
  assign dmem.dmem_be    = mem_op ? byte_enables(funct3_q, alu_result_q[1:0]) : 4'b0000;

  assign reg_write_m  = reg_write_q & ~misaligned;
  assign result_src_m = result_src_q;
  assign alu_result_m = alu_result_q;
  assign rd_m         = rd_q;
  assign pc_plus4_m   = pc_plus4_q;
  assign read_data_m  = load_q;
  assign stall_m      = stall;
  assign misaligned_m = misaligned;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-lane model of the memory stage.
module tb_load_store_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_write_e, mem_read_e, mem_write_e;
  logic [1:0]  result_src_e;
  logic [2:0]  funct3_e;
  logic [31:0] alu_result_e, write_data_e, pc_plus4_e;
  logic [4:0]  rd_e;
  logic        reg_write_m, stall_m, misaligned_m;
  logic [1:0]  result_src_m;
  logic [31:0] alu_result_m, pc_plus4_m, read_data_m;
  logic [4:0]  rd_m;

  load_store_unit_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dmem_bus ();

  load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .reg_write_e(reg_write_e), .mem_read_e(mem_read_e), .mem_write_e(mem_write_e),
    .result_src_e(result_src_e), .funct3_e(funct3_e), .alu_result_e(alu_result_e),
    .write_data_e(write_data_e), .rd_e(rd_e), .pc_plus4_e(pc_plus4_e),
    .reg_write_m(reg_write_m), .result_src_m(result_src_m), .alu_result_m(alu_result_m),
    .rd_m(rd_m), .pc_plus4_m(pc_plus4_m), .read_data_m(read_data_m),
    .stall_m(stall_m), .misaligned_m(misaligned_m), .dmem(dmem_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rw, mr, mw;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [31:0] alu, wd, pc, rdata;
    logic [4:0]  rd;
    int          g, r;
    bit          noise;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  int n_vec = 0;
  int n_err = 0;

  bit          chk = 1'b0;
  bit          exp_stall, exp_mis, exp_rw, exp_req, exp_store;
  logic [1:0]  exp_rs;
  logic [31:0] exp_alu, exp_pc, exp_addr, exp_wdata, exp_load;
  logic [4:0]  exp_rd;
  logic [3:0]  exp_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_mis(input vec_t v);
    if (!(v.mr || v.mw)) return 1'b0;
    return (int'(v.alu[1:0]) % size_of(v.f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int sz, off;
    logic [3:0] be;
    sz = size_of(f3);
    off = int'(addr[1:0]);
    for (int j = 0; j < 4; j++) be[j] = (j >= off) && (j < off + sz);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz;
    logic [31:0] w;
    sz = size_of(f3);
    for (int j = 0; j < 4; j++) w[8*j +: 8] = wd[8*(j % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int sz, off;
    logic [31:0] v;
    logic [7:0] b;
    sz = size_of(f3);
    off = int'(addr[1:0]);
    v = '0;
    for (int j = 0; j < sz; j++) begin
      if (off + j < 4) begin
        b = rdata[8*(off+j) +: 8];
        v = v | (32'(b) << (8*j));
      end
    end
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
    return v;
  endfunction

  function automatic vec_t mk(input bit rw, input bit mr, input bit mw, input logic [1:0] rs,
                              input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                              input logic [4:0] rd, input logic [31:0] pc, input int g, input int r,
                              input logic [31:0] rdata, input bit noise);
    vec_t v;
    v.rw = rw; v.mr = mr; v.mw = mw; v.rs = rs; v.f3 = f3; v.alu = alu; v.wd = wd;
    v.rd = rd; v.pc = pc; v.g = g; v.r = r; v.rdata = rdata; v.noise = noise;
    return v;
  endfunction

  task automatic drive_e(input vec_t v);
    reg_write_e = v.rw; mem_read_e = v.mr; mem_write_e = v.mw; result_src_e = v.rs;
    funct3_e = v.f3; alu_result_e = v.alu; write_data_e = v.wd; rd_e = v.rd; pc_plus4_e = v.pc;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall_m"}, 32'(stall_m), 32'd0);
    check({tag, "_misaligned_m"}, 32'(misaligned_m), 32'd0);
    check({tag, "_reg_write_m"}, 32'(reg_write_m), 32'd0);
    check({tag, "_result_src_m"}, 32'(result_src_m), 32'd0);
    check({tag, "_alu_result_m"}, alu_result_m, 32'd0);
    check({tag, "_rd_m"}, 32'(rd_m), 32'd0);
    check({tag, "_pc_plus4_m"}, pc_plus4_m, 32'd0);
    check({tag, "_read_data_m"}, read_data_m, 32'd0);
    check({tag, "_dmem_req"}, 32'(dmem_bus.dmem_req), 32'd0);
    check({tag, "_dmem_we"}, 32'(dmem_bus.dmem_we), 32'd0);
    check({tag, "_dmem_addr"}, dmem_bus.dmem_addr, 32'd0);
    check({tag, "_dmem_wdata"}, dmem_bus.dmem_wdata, 32'd0);
    check({tag, "_dmem_be"}, 32'(dmem_bus.dmem_be), 32'd0);
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("stall_m", 32'(stall_m), 32'(exp_stall));
      check("misaligned_m", 32'(misaligned_m), 32'(exp_mis));
      check("reg_write_m", 32'(reg_write_m), 32'(exp_rw));
      check("result_src_m", 32'(result_src_m), 32'(exp_rs));
      check("alu_result_m", alu_result_m, exp_alu);
      check("rd_m", 32'(rd_m), 32'(exp_rd));
      check("pc_plus4_m", pc_plus4_m, exp_pc);
      check("read_data_m", read_data_m, exp_load);
      check("dmem_req", 32'(dmem_bus.dmem_req), 32'(exp_req));
      if (exp_req) begin
        check("dmem_addr", dmem_bus.dmem_addr, exp_addr);
        check("dmem_we", 32'(dmem_bus.dmem_we), 32'(exp_store));
        if (exp_store) begin
          check("dmem_be", 32'(dmem_bus.dmem_be), 32'(exp_be));
          check("dmem_wdata", dmem_bus.dmem_wdata, exp_wdata);
        end
      end
    end
  end

  initial begin
    vec_t v;
    bit   aligned, was_rv;
    int   occ, stall_seen;

    vecs[0]  = mk(0, 0, 1, 2'd0, F3_W,  32'h100, 32'hDEADBEEF, 5'd0,  32'h1004, 0, 0, 32'h0, 0);
    vecs[1]  = mk(1, 0, 0, 2'd0, F3_B,  32'h12345678, 32'h0,   5'd5,  32'h1008, 0, 0, 32'h0, 1);
    vecs[2]  = mk(1, 1, 0, 2'd1, F3_B,  32'h103, 32'h0,        5'd6,  32'h100C, 3, 0, 32'h80123456, 0);
    vecs[3]  = mk(1, 1, 0, 2'd1, F3_HU, 32'h102, 32'h0,        5'd7,  32'h1010, 0, 0, 32'hBEEF1234, 0);
    vecs[4]  = mk(1, 1, 0, 2'd1, F3_H,  32'h102, 32'h0,        5'd8,  32'h1014, 1, 2, 32'hBEEF1234, 1);
    vecs[5]  = mk(0, 0, 1, 2'd0, F3_H,  32'h101, 32'h5555AAAA, 5'd0,  32'h1018, 0, 0, 32'h0, 1);
    vecs[6]  = mk(1, 1, 0, 2'd1, F3_W,  32'h102, 32'h0,        5'd9,  32'h101C, 0, 0, 32'h0, 1);
    vecs[7]  = mk(1, 1, 0, 2'd1, F3_W,  32'h200, 32'h0,        5'd10, 32'h1020, 0, 0, 32'hCAFEF00D, 0);
    vecs[8]  = mk(0, 0, 1, 2'd0, F3_W,  32'h204, 32'h11223344, 5'd0,  32'h1024, 0, 0, 32'h0, 0);
    vecs[9]  = mk(0, 0, 1, 2'd0, F3_B,  32'h007, 32'h000000A5, 5'd0,  32'h1028, 2, 0, 32'h0, 1);
    vecs[10] = mk(0, 0, 1, 2'd0, F3_H,  32'h00A, 32'h00007E81, 5'd0,  32'h102C, 0, 0, 32'h0, 0);
    vecs[11] = mk(1, 1, 0, 2'd2, F3_BU, 32'h001, 32'h0,        5'd11, 32'h1030, 0, 1, 32'h0000F700, 0);
    vecs[12] = mk(0, 0, 0, 2'd0, 3'd0,  32'h0,   32'h0,        5'd0,  32'h0,    0, 0, 32'h0, 0);

    drive_e(vecs[12]);
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = 32'hA5A55A5A;
    exp_load = '0;
    #1 rst = 1'b1;
    #2 check_all_zero("reset");

    check("pin_lb_0x103", model_load(F3_B, 32'h103, 32'h80123456), 32'hFFFFFF80);
    check("pin_lhu_0x102", model_load(F3_HU, 32'h102, 32'hBEEF1234), 32'h0000BEEF);
    check("pin_lh_0x102", model_load(F3_H, 32'h102, 32'hBEEF1234), 32'hFFFFBEEF);
    check("pin_be_sw", 32'(model_be(F3_W, 32'h100)), 32'h0000000F);
    check("pin_be_sb_0x7", 32'(model_be(F3_B, 32'h007)), 32'h00000008);
    check("pin_be_sh_0xa", 32'(model_be(F3_H, 32'h00A)), 32'h0000000C);
    check("pin_wdata_sb", model_wdata(F3_B, 32'h000000A5), 32'hA5A5A5A5);
    check("pin_wdata_sh", model_wdata(F3_H, 32'h00007E81), 32'h7E817E81);

    @(posedge clk); #1;
    rst = 1'b0;
    drive_e(vecs[0]);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      if (i + 1 < NV) drive_e(vecs[i+1]);
      else            drive_e(vecs[12]);
      exp_mis   = model_mis(v);
      aligned   = (v.mr || v.mw) && !exp_mis;
      exp_store = v.mw;
      occ       = !aligned ? 1 : (v.mw ? v.g + 1 : v.g + v.r + 3);
      exp_rw    = v.rw && !exp_mis;
      exp_rs    = v.rs; exp_alu = v.alu; exp_rd = v.rd; exp_pc = v.pc;
      exp_addr  = v.alu & 32'hFFFF_FFFC;
      exp_be    = model_be(v.f3, v.alu);
      exp_wdata = model_wdata(v.f3, v.wd);
      stall_seen = 0;
      for (int k = 0; k < occ; k++) begin
        dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; exp_req = 1'b0;
        if (aligned && k <= v.g) begin
          exp_req = 1'b1;
          dmem_bus.dmem_gnt = (k == v.g);
          dmem_bus.dmem_rvalid = v.noise;
        end else if (aligned && !v.mw && k <= v.g + v.r + 1) begin
          dmem_bus.dmem_rvalid = (k == v.g + v.r + 1);
          dmem_bus.dmem_gnt = v.noise;
        end else if (v.noise) begin
          dmem_bus.dmem_gnt = 1'b1; dmem_bus.dmem_rvalid = 1'b1;
        end
        was_rv = aligned && !v.mw && (k == v.g + v.r + 1);
        dmem_bus.dmem_rdata = was_rv ? v.rdata : 32'hA5A55A5A;
        exp_stall = (k < occ - 1);
        chk = 1'b1;
        @(negedge clk);
        if (stall_m) stall_seen++;
        @(posedge clk); #1;
        if (was_rv) exp_load = model_load(v.f3, v.alu, v.rdata);
      end
      if (i == 0) check("sw_stall_cycles", 32'(stall_seen), 32'd0);
      if (i == 2) check("lb_stall_cycles", 32'(stall_seen), 32'd5);
      if (i == 5) check("sh_mis_stall_cycles", 32'(stall_seen), 32'd0);
      if (i == 7) check("lw_min_stall_cycles", 32'(stall_seen), 32'd2);
    end
    chk = 1'b0;
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0;

    // Reset while a load waits for its data, then a stray rvalid for it.
    drive_e(mk(1, 1, 0, 2'd1, F3_W, 32'h300, 32'h0, 5'd12, 32'h2000, 0, 0, 32'h0, 0));
    @(posedge clk); #1;
    drive_e(vecs[12]);
    dmem_bus.dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_bus.dmem_gnt = 1'b0;
    check("pre_rst_stall", 32'(stall_m), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 check_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("stray_rv_read_data", read_data_m, 32'd0);
    check("stray_rv_stall", 32'(stall_m), 32'd0);
    check("stray_rv_req", 32'(dmem_bus.dmem_req), 32'd0);
    @(posedge clk); #1;
    dmem_bus.dmem_rvalid = 1'b0;
    drive_e(mk(0, 0, 1, 2'd0, F3_W, 32'h40, 32'h01020304, 5'd0, 32'h2004, 0, 0, 32'h0, 0));
    @(negedge clk);
    check("post_rv_read_data", read_data_m, 32'd0);
    @(posedge clk); #1;
    drive_e(vecs[12]);
    dmem_bus.dmem_gnt = 1'b1;
    @(negedge clk);
    check("post_rst_sw_req", 32'(dmem_bus.dmem_req), 32'd1);
    check("post_rst_sw_stall", 32'(stall_m), 32'd0);
    check("post_rst_sw_addr", dmem_bus.dmem_addr, 32'h40);
    check("post_rst_sw_wdata", dmem_bus.dmem_wdata, 32'h01020304);
    @(posedge clk); #1;
    dmem_bus.dmem_gnt = 1'b0;
    @(negedge clk);
    check("post_rst_idle_req", 32'(dmem_bus.dmem_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
